// File: rtl/pipe_stall_regs_if.sv
// Bundle between the fetch/decode logic and the stall-aware PC, IF/ID and ID/EX registers.
// Optional STALL_CNT_EN adds the load-use and flush counter outputs.
interface pipe_stall_regs_if #(
    parameter int CTRL_W = 16
);
    logic              stop_IF;
    logic              stop_ID;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [31:0]       if_instr;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_wr;
    logic              id_isLoad;
    logic [CTRL_W-1:0] id_ctrl;

    logic [31:0]       pc_IF;
    logic [31:0]       pc_ID;
    logic [31:0]       instr_ID;
    logic              valid_ID;
    logic [31:0]       pc_EX;
    logic [4:0]        rs1_EX;
    logic [4:0]        rs2_EX;
    logic [4:0]        wr_EX;
    logic              isLoad_EX;
    logic [CTRL_W-1:0] ctrl_EX;
    logic              valid_EX;
`ifdef STALL_CNT_EN
    logic [31:0]       loaduse_cnt;
    logic [31:0]       flush_cnt;
`endif

    modport master (
        output stop_IF, stop_ID, redirect_valid, redirect_pc,
        output if_instr, id_rs1, id_rs2, id_wr, id_isLoad, id_ctrl,
        input  pc_IF, pc_ID, instr_ID, valid_ID,
        input  pc_EX, rs1_EX, rs2_EX, wr_EX, isLoad_EX, ctrl_EX, valid_EX
`ifdef STALL_CNT_EN
        , input loaduse_cnt, flush_cnt
`endif
    );

    modport slave (
        input  stop_IF, stop_ID, redirect_valid, redirect_pc,
        input  if_instr, id_rs1, id_rs2, id_wr, id_isLoad, id_ctrl,
        output pc_IF, pc_ID, instr_ID, valid_ID,
        output pc_EX, rs1_EX, rs2_EX, wr_EX, isLoad_EX, ctrl_EX, valid_EX
`ifdef STALL_CNT_EN
        , output loaduse_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/pipe_stall_regs.sv
// PC, IF/ID and ID/EX pipeline registers with load-use stall and redirect flush.
// Optional STALL_CNT_EN adds saturating load-use and flush cycle counters.
module pipe_stall_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_stall_regs_if.slave       bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       pc_id_q, pc_id_d;
    logic [31:0]       instr_id_q, instr_id_d;
    logic              valid_id_q, valid_id_d;
    logic [31:0]       pc_ex_q, pc_ex_d;
    logic [4:0]        rs1_ex_q, rs1_ex_d;
    logic [4:0]        rs2_ex_q, rs2_ex_d;
    logic [4:0]        wr_ex_q, wr_ex_d;
    logic              isload_ex_q, isload_ex_d;
    logic [CTRL_W-1:0] ctrl_ex_q, ctrl_ex_d;
    logic              valid_ex_q, valid_ex_d;

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (!bus.stop_IF) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;
        valid_id_d = valid_id_q;
        if (bus.redirect_valid) begin
            pc_id_d    = pc_q;
            instr_id_d = NOP;
            valid_id_d = 1'b0;
        end else if (!bus.stop_IF) begin
            pc_id_d    = pc_q;
            instr_id_d = bus.if_instr;
            valid_id_d = 1'b1;
        end
    end

    // An invalid ID slot must never carry a destination or load flag forward.
    always_comb begin
        pc_ex_d     = pc_id_q;
        rs1_ex_d    = '0;
        rs2_ex_d    = '0;
        wr_ex_d     = '0;
        isload_ex_d = 1'b0;
        ctrl_ex_d   = '0;
        valid_ex_d  = 1'b0;
        if (!(bus.stop_ID || bus.redirect_valid)) begin
            rs1_ex_d   = bus.id_rs1;
            rs2_ex_d   = bus.id_rs2;
            valid_ex_d = valid_id_q;
            if (valid_id_q) begin
                wr_ex_d     = bus.id_wr;
                isload_ex_d = bus.id_isLoad;
                ctrl_ex_d   = bus.id_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            pc_id_q     <= RESET_PC;
            instr_id_q  <= NOP;
            valid_id_q  <= 1'b0;
            pc_ex_q     <= '0;
            rs1_ex_q    <= '0;
            rs2_ex_q    <= '0;
            wr_ex_q     <= '0;
            isload_ex_q <= 1'b0;
            ctrl_ex_q   <= '0;
            valid_ex_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pc_id_q     <= pc_id_d;
            instr_id_q  <= instr_id_d;
            valid_id_q  <= valid_id_d;
            pc_ex_q     <= pc_ex_d;
            rs1_ex_q    <= rs1_ex_d;
            rs2_ex_q    <= rs2_ex_d;
            wr_ex_q     <= wr_ex_d;
            isload_ex_q <= isload_ex_d;
            ctrl_ex_q   <= ctrl_ex_d;
            valid_ex_q  <= valid_ex_d;
        end
    end

    assign bus.pc_IF     = pc_q;
    assign bus.pc_ID     = pc_id_q;
    assign bus.instr_ID  = instr_id_q;
    assign bus.valid_ID  = valid_id_q;
    assign bus.pc_EX     = pc_ex_q;
    assign bus.rs1_EX    = rs1_ex_q;
    assign bus.rs2_EX    = rs2_ex_q;
    assign bus.wr_EX     = wr_ex_q;
    assign bus.isLoad_EX = isload_ex_q;
    assign bus.ctrl_EX   = ctrl_ex_q;
    assign bus.valid_EX  = valid_ex_q;

`ifdef STALL_CNT_EN
    logic [31:0] loaduse_cnt_q, loaduse_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // A redirect overrides a coincident stall, so it only counts as a flush.
    always_comb begin
        loaduse_cnt_d = loaduse_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (bus.redirect_valid) begin
            if (flush_cnt_q != 32'hFFFF_FFFF) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end else if (bus.stop_IF) begin
            if (loaduse_cnt_q != 32'hFFFF_FFFF) begin
                loaduse_cnt_d = loaduse_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loaduse_cnt_q <= '0;
            flush_cnt_q   <= '0;
        end else begin
            loaduse_cnt_q <= loaduse_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign bus.loaduse_cnt = loaduse_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stall_regs.sv
// Directed checks of the PC, IF/ID and ID/EX stall/flush registers.
// Counter checks compile in when STALL_CNT_EN is defined.
module tb_pipe_stall_regs;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pipe_stall_regs_if #(.CTRL_W(16)) bus ();

    pipe_stall_regs #(
        .RESET_PC (32'h0000_0000),
        .CTRL_W   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction memory model: word at PC p reads as {A5A5, p[15:0]}.
    task automatic step();
        bus.if_instr = {16'hA5A5, bus.pc_IF[15:0]};
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stop_IF        = 1'b0;
        bus.stop_ID        = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.stop_IF        = 1'b1;
        bus.stop_ID        = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0500;
        bus.if_instr       = 32'h0;
        bus.id_rs1         = 5'd1;
        bus.id_rs2         = 5'd2;
        bus.id_wr          = 5'd3;
        bus.id_isLoad      = 1'b1;
        bus.id_ctrl        = 16'hBEEF;
        step();
        step();
        chk("rst_pc_IF", bus.pc_IF, 32'h0);
        chk("rst_pc_ID", bus.pc_ID, 32'h0);
        chk("rst_instr_ID", bus.instr_ID, NOP);
        chk("rst_valid_ID", bus.valid_ID, 1'b0);
        chk("rst_valid_EX", bus.valid_EX, 1'b0);
        chk("rst_wr_EX", bus.wr_EX, 5'd0);
        chk("rst_ctrl_EX", bus.ctrl_EX, 16'h0);
        chk("rst_rs1_EX", bus.rs1_EX, 5'd0);
`ifdef STALL_CNT_EN
        chk("rst_loaduse", bus.loaduse_cnt, 32'd0);
        chk("rst_flush", bus.flush_cnt, 32'd0);
`endif

        rst = 1'b0;
        idle();
        step();
        chk("c1_pc_IF", bus.pc_IF, 32'h4);
        chk("c1_valid_ID", bus.valid_ID, 1'b1);
        chk("c1_instr_ID", bus.instr_ID, 32'hA5A5_0000);
        chk("c1_valid_EX", bus.valid_EX, 1'b0);
        chk("c1_wr_EX_phantom", bus.wr_EX, 5'd0);
        chk("c1_isLoad_EX_phantom", bus.isLoad_EX, 1'b0);
        step();
        chk("c2_pc_IF", bus.pc_IF, 32'h8);
        chk("c2_valid_EX", bus.valid_EX, 1'b1);
        chk("c2_wr_EX", bus.wr_EX, 5'd3);
        chk("c2_ctrl_EX", bus.ctrl_EX, 16'hBEEF);
        chk("c2_rs2_EX", bus.rs2_EX, 5'd2);
        chk("c2_pc_EX", bus.pc_EX, 32'h0);
        step();
        chk("c3_pc_IF", bus.pc_IF, 32'hC);
        step();
        chk("c4_pc_IF", bus.pc_IF, 32'h10);
        chk("c4_instr_ID", bus.instr_ID, 32'hA5A5_000C);

        bus.stop_IF = 1'b1;
        bus.stop_ID = 1'b1;
        step();
        chk("lu_pc_IF", bus.pc_IF, 32'h10);
        chk("lu_instr_ID", bus.instr_ID, 32'hA5A5_000C);
        chk("lu_pc_ID", bus.pc_ID, 32'hC);
        chk("lu_valid_EX", bus.valid_EX, 1'b0);
        chk("lu_wr_EX", bus.wr_EX, 5'd0);
        chk("lu_pc_EX", bus.pc_EX, 32'hC);
        idle();
        step();
        chk("lu_resume_pc_IF", bus.pc_IF, 32'h14);
        chk("lu_resume_instr_ID", bus.instr_ID, 32'hA5A5_0010);
        chk("lu_resume_valid_EX", bus.valid_EX, 1'b1);
        chk("lu_resume_pc_EX", bus.pc_EX, 32'hC);

        bus.stop_IF = 1'b1;
        bus.stop_ID = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("long_stall_pc_IF", bus.pc_IF, 32'h14);
        chk("long_stall_instr_ID", bus.instr_ID, 32'hA5A5_0010);
        chk("long_stall_valid_ID", bus.valid_ID, 1'b1);

        bus.stop_ID = 1'b0;
        bus.id_wr   = 5'd7;
        $display("note: stop_IF=1 with stop_ID=0 pairing driven");
        step();
        chk("odd_pc_IF", bus.pc_IF, 32'h14);
        chk("odd_pc_ID", bus.pc_ID, 32'h10);
        chk("odd_valid_EX", bus.valid_EX, 1'b1);
        chk("odd_wr_EX", bus.wr_EX, 5'd7);
        chk("odd_pc_EX", bus.pc_EX, 32'h10);
        idle();
        bus.id_wr = 5'd3;
        step();
        chk("odd_resume_pc_IF", bus.pc_IF, 32'h18);
        chk("odd_resume_instr_ID", bus.instr_ID, 32'hA5A5_0014);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        step();
        chk("rd_pc_IF", bus.pc_IF, 32'h200);
        chk("rd_valid_ID", bus.valid_ID, 1'b0);
        chk("rd_instr_ID", bus.instr_ID, NOP);
        chk("rd_pc_ID", bus.pc_ID, 32'h18);
        chk("rd_valid_EX", bus.valid_EX, 1'b0);
        idle();
        step();
        chk("rd_next_pc_IF", bus.pc_IF, 32'h204);
        chk("rd_next_valid_ID", bus.valid_ID, 1'b1);
        chk("rd_next_valid_EX", bus.valid_EX, 1'b0);
        chk("rd_next_ctrl_EX", bus.ctrl_EX, 16'h0);

        bus.stop_IF        = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0080;
        step();
        chk("both_pc_IF", bus.pc_IF, 32'h80);
        chk("both_valid_ID", bus.valid_ID, 1'b0);
        chk("both_valid_EX", bus.valid_EX, 1'b0);
`ifdef STALL_CNT_EN
        chk("cnt_loaduse", bus.loaduse_cnt, 32'd5);
        chk("cnt_flush", bus.flush_cnt, 32'd2);
`endif

        bus.stop_IF     = 1'b0;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap_pre_pc_IF", bus.pc_IF, 32'hFFFF_FFFC);
        idle();
        step();
        chk("wrap_pc_IF", bus.pc_IF, 32'h0000_0000);
        chk("wrap_pc_ID", bus.pc_ID, 32'hFFFF_FFFC);

        step();
        rst                = 1'b1;
        bus.stop_IF        = 1'b1;
        bus.redirect_valid = 1'b1;
        step();
        chk("mid_rst_pc_IF", bus.pc_IF, 32'h0);
        chk("mid_rst_valid_ID", bus.valid_ID, 1'b0);
        chk("mid_rst_valid_EX", bus.valid_EX, 1'b0);
`ifdef STALL_CNT_EN
        chk("mid_rst_loaduse", bus.loaduse_cnt, 32'd0);
        chk("mid_rst_flush", bus.flush_cnt, 32'd0);
`endif
        rst = 1'b0;
        idle();
        step();
        chk("post_rst_pc_IF", bus.pc_IF, 32'h4);
        chk("post_rst_instr_ID", bus.instr_ID, 32'hA5A5_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stall_regs.md
PIPE_STALL_REGS -- requirements
Module: pipe_stall_regs

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter CTRL_W, default 16, giving the width of the decoded control bundle.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port stop_IF, input, 1 bit: hold PC and the IF/ID register (load-use stall).
REQ-006 The block SHALL have port stop_ID, input, 1 bit: load a bubble into the ID/EX register.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: branch/jump mispredict resolved in EX.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits: corrected fetch address.
REQ-009 The block SHALL have port if_instr, input, 32 bits: instruction fetched at pc_IF.
REQ-010 The block SHALL have ports id_rs1, id_rs2 and id_wr, input, 5 bits each: decoded register fields from ID.
REQ-011 The block SHALL have port id_isLoad, input, 1 bit: the ID instruction is a load.
REQ-012 The block SHALL have port id_ctrl, input, CTRL_W bits: decoded control bundle from ID.
REQ-013 The block SHALL have port pc_IF, output, 32 bits: current fetch PC.
REQ-014 The block SHALL have ports pc_ID, instr_ID and valid_ID, output, 32/32/1 bits: the IF/ID register.
REQ-015 The block SHALL have ports pc_EX, rs1_EX, rs2_EX, wr_EX, isLoad_EX, ctrl_EX and valid_EX, output, 32/5/5/5/1/CTRL_W/1 bits: the ID/EX register.

Function
REQ-016 The PC SHALL update each cycle with priority redirect_valid (redirect_pc), then stop_IF (hold), then pc_IF+4, wrapping modulo 2^32.
REQ-017 When redirect_valid=1, the IF/ID register SHALL load valid_ID=0, instr_ID=32'h0000_0013 (NOP) and pc_ID=pc_IF.
REQ-018 Otherwise, when stop_IF=1, the IF/ID register SHALL hold all fields.
REQ-019 Otherwise, the IF/ID register SHALL load pc_IF, if_instr and valid_ID=1.
REQ-020 When stop_ID=1 or redirect_valid=1, the ID/EX register SHALL load a bubble: valid_EX=0, wr_EX=0, isLoad_EX=0, ctrl_EX=0, rs1_EX=0, rs2_EX=0, pc_EX=pc_ID.
REQ-021 Otherwise, the ID/EX register SHALL load pc_ID, id_rs1, id_rs2, id_wr, id_isLoad and id_ctrl, with valid_EX=valid_ID.
REQ-022 When valid_ID=0, the ID/EX load SHALL force wr_EX=0, isLoad_EX=0 and ctrl_EX=0, so no phantom hazard is raised.
REQ-023 Latency SHALL be one cycle per register stage, with no combinational path from any input to any output.
REQ-024 When stop_IF=1 and redirect_valid=1 arrive together, redirect SHALL win for PC and IF/ID, and the ID/EX register SHALL take a bubble.
REQ-025 When stop_IF=1 and stop_ID=0 arrive together (illegal pairing), the block SHALL hold IF/ID and load ID/EX normally; the bench flags this pairing but it is not fatal.
REQ-026 The block SHALL sustain consecutive stall cycles indefinitely without loss of the held instruction.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set pc_IF=RESET_PC, pc_ID=RESET_PC, instr_ID=NOP, valid_ID=0, and zero every ID/EX field.
REQ-028 Reset SHALL override stop_IF, stop_ID and redirect_valid in the same cycle.
REQ-029 On the first edge after rst deasserts, the block SHALL fetch from RESET_PC.

Configuration
REQ-030 When macro STALL_CNT_EN is defined, the block SHALL add outputs loaduse_cnt[31:0] (cycles with stop_IF=1 and redirect_valid=0) and flush_cnt[31:0] (cycles with redirect_valid=1).
REQ-031 Both counters SHALL be reset to 0 and SHALL saturate at 32'hFFFF_FFFF.
REQ-032 When STALL_CNT_EN is undefined, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset then 3 free cycles -> pc_IF sequence 0x0, 0x4, 0x8, 0xC; valid_ID=1 from cycle 2.
REQ-034 Load-use: stop_IF=stop_ID=1 for 1 cycle at pc_IF=0x10 -> pc_IF holds 0x10, instr_ID is unchanged, valid_EX=0, wr_EX=0 next cycle; the pipeline resumes at 0x14.
REQ-035 Redirect: redirect_valid=1 with redirect_pc=0x200 -> next cycle pc_IF=0x200, valid_ID=0, instr_ID=0x00000013, valid_EX=0.
REQ-036 Simultaneous stop_IF=1 and redirect_valid=1 with redirect_pc=0x80 -> pc_IF=0x80 and valid_ID=0 (redirect wins).
REQ-037 pc_IF=0xFFFF_FFFC with no stall -> next pc_IF=0x0000_0000.
REQ-038 With STALL_CNT_EN defined: 5 load-use cycles and 2 redirects -> loaduse_cnt=5 and flush_cnt=2; rst asserted mid-run -> both counters 0.
